// File: rtl/axi_stream_if.sv
// AXI-Stream bundle carried between the egress switch, the packet FIFO and its consumer.
interface axi_stream_if;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned USER_W = 16;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic [USER_W-1:0] user_size;
  logic [USER_W-1:0] user_src;
  logic [USER_W-1:0] user_dst;

  modport master (
    output valid, data, keep, last, user_size, user_src, user_dst,
    input  ready
  );

  modport slave (
    input  valid, data, keep, last, user_size, user_src, user_dst,
    output ready
  );
endinterface

// File: rtl/egress_packet_fifo.sv
// Store-and-forward egress packet FIFO with cut-through fallback for packets larger than the buffer.
module egress_packet_fifo #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_PKTS = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axi_stream_if.slave               s_axis,
  axi_stream_if.master              m_axis,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [$clog2(MAX_PKTS):0] pkt_count,
  output logic                      cut_through
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned OCC_W  = AW + 1;
  localparam int unsigned PKT_W  = $clog2(MAX_PKTS) + 1;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned USER_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user_size;
    logic [USER_W-1:0] user_src;
    logic [USER_W-1:0] user_dst;
  } entry_t;

  // Release mode: store-and-forward normally, cut-through only for an oversize packet.
  typedef enum logic {
    MODE_SF = 1'b0,
    MODE_CT = 1'b1
  } mode_e;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OCC_W-1:0] r_occupancy;
  logic [PKT_W-1:0] r_pkt_count;
  mode_e            r_mode;
  mode_e            w_mode_nxt;

  entry_t w_wr_entry;
  entry_t w_rd_entry;
  logic   w_s_ready;
  logic   w_m_valid;
  logic   w_wr_en;
  logic   w_rd_en;
  logic   w_wr_last;
  logic   w_rd_last;
  logic   w_full_no_pkt;

  // Ready depends on registered state only, so a same-cycle read never feeds back into ready.
  assign w_s_ready = (r_occupancy < OCC_W'(DEPTH)) && (r_pkt_count < PKT_W'(MAX_PKTS));
  assign w_m_valid = (r_pkt_count != '0) || ((r_mode == MODE_CT) && (r_occupancy != '0));

  assign w_wr_en   = s_axis.valid && w_s_ready;
  assign w_rd_en   = w_m_valid && m_axis.ready;
  assign w_wr_last = w_wr_en && s_axis.last;
  assign w_rd_last = w_rd_en && w_rd_entry.last;

  assign w_full_no_pkt = (r_occupancy == OCC_W'(DEPTH)) && (r_pkt_count == '0);

  assign w_wr_entry = '{data:      s_axis.data,
                        keep:      s_axis.keep,
                        last:      s_axis.last,
                        user_size: s_axis.user_size,
                        user_src:  s_axis.user_src,
                        user_dst:  s_axis.user_dst};
  assign w_rd_entry = r_mem[r_rd_ptr];

  assign s_axis.ready     = w_s_ready;
  assign m_axis.valid     = w_m_valid;
  assign m_axis.data      = w_rd_entry.data;
  assign m_axis.keep      = w_rd_entry.keep;
  assign m_axis.last      = w_rd_entry.last;
  assign m_axis.user_size = w_rd_entry.user_size;
  assign m_axis.user_src  = w_rd_entry.user_src;
  assign m_axis.user_dst  = w_rd_entry.user_dst;

  assign occupancy   = r_occupancy;
  assign pkt_count   = r_pkt_count;
  assign cut_through = (r_mode == MODE_CT);

  // Beat storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Beat and complete-packet counters; simultaneous inc/dec cancel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_occupancy <= '0;
      r_pkt_count <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
        2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
      case ({w_wr_last, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + PKT_W'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PKT_W'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Release-mode state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mode <= MODE_SF;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Enter cut-through when full with no complete packet; leave on the last beat read.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_SF: if (w_full_no_pkt) w_mode_nxt = MODE_CT;
      MODE_CT: if (w_rd_last)     w_mode_nxt = MODE_SF;
      default: w_mode_nxt = MODE_SF;
    endcase
  end

endmodule

// File: tb/tb_egress_packet_fifo.sv
// Bench for egress_packet_fifo: cycle table, scoreboard-checked streams and multi-cycle corner cases.
module tb_egress_packet_fifo;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned MAX_PKTS = 4;
  localparam int unsigned OCC_W    = $clog2(DEPTH) + 1;
  localparam int unsigned PKT_W    = $clog2(MAX_PKTS) + 1;
  localparam int unsigned NROWS    = 28;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [15:0]  size;
    logic [15:0]  src;
    logic [15:0]  dst;
  } beat_t;

  typedef struct {
    logic        s_valid;
    logic        s_last;
    logic [15:0] s_dst;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    int          exp_occ;
    int          exp_pkt;
    logic        exp_ct;
  } vec_t;

  logic             aclk;
  logic             aresetn;
  logic [OCC_W-1:0] occupancy;
  logic [PKT_W-1:0] pkt_count;
  logic             cut_through;

  axi_stream_if s_if ();
  axi_stream_if m_if ();

  egress_packet_fifo #(.DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .occupancy   (occupancy),
    .pkt_count   (pkt_count),
    .cut_through (cut_through)
  );

  int    checks;
  int    failures;
  beat_t sb[$];
  int    bp_mode;     // 0 always ready, 1 stalled, 2 random, 3 table-driven
  logic  man_ready;
  logic  rnd_ready;
  vec_t  tbl [NROWS];

  assign m_if.ready = (bp_mode == 0) ? 1'b1 :
                      (bp_mode == 1) ? 1'b0 :
                      (bp_mode == 2) ? rnd_ready : man_ready;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got dst=%h src=%h size=%h last=%b data=%h expected dst=%h src=%h size=%h last=%b data=%h",
               name, act.dst, act.src, act.size, act.last, act.data[127:0],
               exp.dst, exp.src, exp.size, exp.last, exp.data[127:0]);
    end
  endtask

  function automatic beat_t mk_beat(input logic last, input logic [15:0] dst);
    beat_t b;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom();
    b.keep = {$urandom(), $urandom()};
    b.last = last;
    b.size = 16'($urandom());
    b.src  = 16'($urandom());
    b.dst  = dst;
    return b;
  endfunction

  function automatic vec_t mkv(input logic sv, input logic sl, input logic [15:0] dst, input logic mr,
                               input logic er, input logic emv, input int eo, input int ep, input logic ect);
    vec_t v;
    v.s_valid = sv; v.s_last = sl; v.s_dst = dst; v.m_ready = mr;
    v.exp_s_ready = er; v.exp_m_valid = emv; v.exp_occ = eo; v.exp_pkt = ep; v.exp_ct = ect;
    return v;
  endfunction

  task automatic drive_fields(input beat_t b);
    s_if.data      = b.data;
    s_if.keep      = b.keep;
    s_if.last      = b.last;
    s_if.user_size = b.size;
    s_if.user_src  = b.src;
    s_if.user_dst  = b.dst;
  endtask

  // Present one beat until accepted; the accepted beat becomes an expected output.
  task automatic send_beat(input beat_t b);
    bit ok;
    ok = 1'b0;
    drive_fields(b);
    s_if.valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge aclk);
      if (s_if.ready) begin
        ok = 1'b1;
        sb.push_back(b);
      end
      @(posedge aclk);
      #1;
    end
    s_if.valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 2000 cycles");
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (sb.size() == 0 && occupancy == '0) break;
    end
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_occ_zero"}, 64'(occupancy), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  // Output monitor: scoreboard compare, stall stability and intra-packet gap rules.
  initial begin
    beat_t cur;
    beat_t exp;
    beat_t prev_beat;
    logic  prev_stall;
    logic  in_pkt;
    prev_stall = 1'b0;
    in_pkt     = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
      end else begin
        cur = {m_if.data, m_if.keep, m_if.last, m_if.user_size, m_if.user_src, m_if.user_dst};
        if (prev_stall) begin
          check("stall_valid_hold", 64'(m_if.valid), 64'd1);
          check_beat("stall_fields_hold", cur, prev_beat);
        end
        if (in_pkt) check("no_sf_gap", 64'(m_if.valid | cut_through), 64'd1);
        if (m_if.valid && m_if.ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected: got beat dst=%h expected no output", cur.dst);
          end else begin
            exp = sb.pop_front();
            check_beat("out_beat", cur, exp);
          end
          in_pkt = !cur.last;
        end
        prev_stall = m_if.valid && !m_if.ready;
        prev_beat  = cur;
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // Main sequence.
  initial begin
    checks    = 0;
    failures  = 0;
    bp_mode   = 3;
    man_ready = 1'b1;
    s_if.valid = 1'b0;
    drive_fields('0);

    //             sv sl dst       mr  er mv occ pkt ct
    tbl[0]  = mkv(0, 0, 16'h0000, 1,  1, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 1, 16'h0401, 1,  1, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 16'h0000, 1,  1, 1, 1, 1, 0);
    tbl[3]  = mkv(0, 0, 16'h0000, 1,  1, 0, 0, 0, 0);
    tbl[4]  = mkv(1, 0, 16'h0A00, 1,  1, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 0, 16'h0A01, 1,  1, 0, 1, 0, 0);
    tbl[6]  = mkv(1, 0, 16'h0A02, 1,  1, 0, 2, 0, 0);
    tbl[7]  = mkv(0, 0, 16'h0000, 1,  1, 0, 3, 0, 0);
    tbl[8]  = mkv(0, 0, 16'h0000, 1,  1, 0, 3, 0, 0);
    tbl[9]  = mkv(1, 1, 16'h0A03, 1,  1, 0, 3, 0, 0);
    tbl[10] = mkv(0, 0, 16'h0000, 1,  1, 1, 4, 1, 0);
    tbl[11] = mkv(0, 0, 16'h0000, 1,  1, 1, 3, 1, 0);
    tbl[12] = mkv(0, 0, 16'h0000, 1,  1, 1, 2, 1, 0);
    tbl[13] = mkv(0, 0, 16'h0000, 1,  1, 1, 1, 1, 0);
    tbl[14] = mkv(0, 0, 16'h0000, 1,  1, 0, 0, 0, 0);
    tbl[15] = mkv(1, 0, 16'h0B00, 0,  1, 0, 0, 0, 0);
    tbl[16] = mkv(1, 0, 16'h0B01, 0,  1, 0, 1, 0, 0);
    tbl[17] = mkv(1, 1, 16'h0B02, 0,  1, 0, 2, 0, 0);
    tbl[18] = mkv(1, 0, 16'h0B10, 0,  1, 1, 3, 1, 0);
    tbl[19] = mkv(1, 0, 16'h0B11, 0,  1, 1, 4, 1, 0);
    tbl[20] = mkv(1, 1, 16'h0B12, 0,  1, 1, 5, 1, 0);
    tbl[21] = mkv(1, 0, 16'h0B20, 0,  1, 1, 6, 2, 0);
    tbl[22] = mkv(1, 0, 16'h0B21, 0,  1, 1, 7, 2, 0);
    tbl[23] = mkv(1, 1, 16'h0B22, 0,  0, 1, 8, 2, 0);
    tbl[24] = mkv(1, 1, 16'h0B22, 0,  0, 1, 8, 2, 0);
    tbl[25] = mkv(1, 1, 16'h0B22, 1,  0, 1, 8, 2, 0);
    tbl[26] = mkv(1, 1, 16'h0B22, 1,  1, 1, 7, 2, 0);
    tbl[27] = mkv(0, 0, 16'h0000, 1,  1, 1, 7, 3, 0);

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_ct", 64'(cut_through), 64'd0);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_s_ready", 64'(s_if.ready), 64'd1);
    @(posedge aclk);
    #1;

    // Cycle table: single packet latency, store-and-forward hold, full condition
    for (int r = 0; r < int'(NROWS); r++) begin
      beat_t b;
      b = mk_beat(tbl[r].s_last, tbl[r].s_dst);
      man_ready = tbl[r].m_ready;
      drive_fields(b);
      s_if.valid = tbl[r].s_valid;
      @(negedge aclk);
      check($sformatf("row%0d_s_ready", r), 64'(s_if.ready), 64'(tbl[r].exp_s_ready));
      check($sformatf("row%0d_m_valid", r), 64'(m_if.valid), 64'(tbl[r].exp_m_valid));
      check($sformatf("row%0d_occ", r), 64'(occupancy), 64'(tbl[r].exp_occ));
      check($sformatf("row%0d_pkt", r), 64'(pkt_count), 64'(tbl[r].exp_pkt));
      check($sformatf("row%0d_ct", r), 64'(cut_through), 64'(tbl[r].exp_ct));
      if (s_if.valid && s_if.ready) sb.push_back(b);
      @(posedge aclk);
      #1;
    end
    s_if.valid = 1'b0;
    bp_mode = 0;
    wait_drain("table", 100);

    // Packet-count limit with beat space remaining
    bp_mode = 1;
    for (int i = 0; i < int'(MAX_PKTS); i++) send_beat(mk_beat(1'b1, 16'(16'h0C00 + i)));
    @(negedge aclk);
    check("pktlim_s_ready", 64'(s_if.ready), 64'd0);
    check("pktlim_occ", 64'(occupancy), 64'(MAX_PKTS));
    check("pktlim_pkt", 64'(pkt_count), 64'(MAX_PKTS));
    @(posedge aclk);
    #1;
    bp_mode = 0;
    wait_drain("pktlim", 100);

    // Oversize packet falls back to cut-through
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(mk_beat(i == 11, 16'(16'h0D00 + i)));
      end
      begin
        bit seen;
        bit got_last;
        seen = 1'b0;
        got_last = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge aclk);
          if (occupancy == OCC_W'(DEPTH)) seen = 1'b1;
        end
        check("ovs_full_reached", 64'(seen), 64'd1);
        check("ovs_full_pkt", 64'(pkt_count), 64'd0);
        @(negedge aclk);
        check("ovs_ct_set", 64'(cut_through), 64'd1);
        check("ovs_m_valid", 64'(m_if.valid), 64'd1);
        for (int i = 0; i < 400 && !got_last; i++) begin
          @(negedge aclk);
          if (m_if.valid && m_if.ready && m_if.last) got_last = 1'b1;
        end
        check("ovs_last_seen", 64'(got_last), 64'd1);
        @(negedge aclk);
        check("ovs_ct_clear", 64'(cut_through), 64'd0);
      end
    join
    wait_drain("oversize", 100);

    // Random packets under random backpressure
    bp_mode = 2;
    for (int p = 0; p < 100; p++) begin
      int len;
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge aclk);
          #1;
        end
        send_beat(mk_beat(k == len - 1, 16'(p)));
      end
    end
    wait_drain("random", 5000);

    // Reset in the middle of a packet
    bp_mode = 1;
    send_beat(mk_beat(1'b0, 16'h0E00));
    send_beat(mk_beat(1'b0, 16'h0E01));
    aresetn = 1'b0;
    #1;
    sb.delete();
    check("mrst_occ", 64'(occupancy), 64'd0);
    check("mrst_pkt", 64'(pkt_count), 64'd0);
    check("mrst_ct", 64'(cut_through), 64'd0);
    check("mrst_m_valid", 64'(m_if.valid), 64'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("mrst_s_ready", 64'(s_if.ready), 64'd1);
    check("mrst_m_valid_after", 64'(m_if.valid), 64'd0);
    @(posedge aclk);
    #1;
    bp_mode = 0;
    send_beat(mk_beat(1'b0, 16'h0F00));
    send_beat(mk_beat(1'b1, 16'h0F01));
    wait_drain("postrst", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/egress_packet_fifo.md
# egress_packet_fifo

Store-and-forward packet FIFO placed on each output of the egress switch, between one `m_axis_pf[i]` / `m_axis_cmac[i]` port and its QDMA or CMAC transmit path. It buffers whole packets so the consumer sees each packet as a gap-free burst of beats. It also decouples egress-switch throughput from consumer backpressure. Packets longer than the buffer fall back to cut-through, so the block cannot deadlock.

## Interface
Parameters:
- `DEPTH`, 64: beat capacity of the buffer; power of two, at least 4.
- `MAX_PKTS`, 16: maximum number of complete packets held; power of two.

Ports:
- `aclk`, in, 1: clock; all logic on the rising edge.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `s_axis`, axi_stream_if.slave: from the egress switch. Fields: `valid`, `ready`, `data`[511:0], `keep`[63:0], `last`, `user_size`[15:0], `user_src`[15:0], `user_dst`[15:0].
- `m_axis`, axi_stream_if.master: to the consumer; same fields as `s_axis`.
- `occupancy`, out, $clog2(DEPTH)+1: beats currently stored.
- `pkt_count`, out, $clog2(MAX_PKTS)+1: complete packets stored, counted by last beats written and not yet read.
- `cut_through`, out, 1: the oversize-packet release mode is active.

## Operation
- Storage is one entry per beat: `data`, `keep`, `last`, `user_size`, `user_src` and `user_dst`, all kept per beat.
- Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write: on an `s_axis` handshake (`valid && ready`), store the entry at `wr_ptr` and increment `wr_ptr`.
- Input ready: `s_axis.ready = (occupancy < DEPTH) && (pkt_count < MAX_PKTS)`.
- Read: the output is first-word-fall-through. `m_axis` fields are driven combinationally from the entry at `rd_ptr`. On an `m_axis` handshake, increment `rd_ptr`.
- Output valid: `m_axis.valid = (pkt_count != 0) || (cut_through && occupancy != 0)`.
- `occupancy` update: +1 on write only, -1 on read only, unchanged when both occur in the same cycle.
- `pkt_count` update: +1 on a write with `last`, -1 on a read with `last`, unchanged when both occur in the same cycle.
- Cut-through entry: `cut_through` sets when `occupancy == DEPTH` and `pkt_count == 0`, meaning the buffer is full with no complete packet stored.
- Cut-through exit: `cut_through` clears on the `m_axis` handshake that carries `last`. Clear has priority over set in the same cycle.
- Cut-through gaps: while active, `m_axis.valid` may deassert mid-packet when the buffer drains. This gap is the only permitted output gap inside a packet.
- No data transformation: every field leaves exactly as it entered. No reordering. No drops.

## Timing
- Reset values:
  - `m_axis.valid` = 0.
  - `occupancy` = 0, `pkt_count` = 0, `cut_through` = 0.
  - `wr_ptr` = `rd_ptr` = 0.
  - `s_axis.ready` = 1 once reset is released.
  - Memory contents are don't-care.
- Reset mid-packet discards all stored beats and any partial packet.
- Latency: a `last` beat written in cycle t makes `m_axis.valid` = 1 in cycle t+1 for that packet's first beat.
- Minimum latency, for a 1-beat packet into an empty buffer, is 1 cycle.
- Once a packet is released in store-and-forward mode, `m_axis.valid` stays 1 for every beat through `last`.
- Throughput: one beat in and one beat out per cycle. Full rate is sustained when the consumer holds `ready` = 1.
- Output stability: while `m_axis.valid && !m_axis.ready`, all `m_axis` fields hold stable.
- Full condition: `s_axis.ready` drops combinationally once `occupancy == DEPTH`. A read in that cycle does not raise `ready` until the next cycle, so there is no combinational ready→ready path.
- Packet-count limit: `pkt_count == MAX_PKTS` deasserts `s_axis.ready` even when beat space remains.

## Test plan
- Single packet: one 1-beat packet, `user_dst` = 0x0401, into an empty FIFO. `m_axis.valid` rises exactly 1 cycle after input; fields match; `pkt_count` goes 0→1→0.
- Store-and-forward hold: send a 4-beat packet with 2 idle cycles before `last`. `m_axis.valid` stays 0 until the cycle after `last` is written, then 4 consecutive output beats follow.
- Streaming with random output backpressure: 100 random packets of 1-20 beats. Output is bit-exact and in order, with no intra-packet `valid` gaps.
- Full condition: with DEPTH=8 and the consumer stalled, send three 3-beat packets. `s_axis.ready` = 0 after 8 beats; `occupancy` = 8, `pkt_count` = 2. Releasing the consumer drains all 9 beats intact.
- Oversize packet: with DEPTH=8, send one 12-beat packet. `cut_through` = 1 when `occupancy` reaches 8, output starts, all 12 beats arrive in order, and `cut_through` clears on `last`.
- Reset mid-operation: assert `aresetn` = 0 after 2 beats of a 4-beat packet. Outputs take their reset values immediately. After release, a new 2-beat packet passes cleanly and no stale beat appears.
